// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stack_arbiter
// Brief    : Round-robin arbiter granting two requesters push/pop access to
//            an external stack register, with occupancy tracking and sticky
//            overflow/underflow flags.
// Revision : 1.0  initial release
// ============================================================================
module stack_arbiter #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          sysclk,
  input  logic          sysreset,
  input  logic          a_req,
  input  logic          a_push,
  input  logic [15:0]   a_wdata,
  output logic [15:0]   a_rdata,
  output logic          a_ack,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_push,
  input  logic [15:0]   b_wdata,
  output logic [15:0]   b_rdata,
  output logic          b_ack,
  output logic          b_err,
  input  logic [15:0]   stk_data_out,
  output logic [15:0]   stk_data_in,
  output logic          stk_load,
  output logic          stk_read,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf,
  input  logic          clr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t        state_q, state_d;
  logic          win_q, win_d;      // 0 = A, 1 = B
  logic          last_q, last_d;    // requester served most recently
  logic          op_push_q, op_push_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [15:0]   a_rdata_q, a_rdata_d;
  logic [15:0]   b_rdata_q, b_rdata_d;

  logic          ovf_set;
  logic          unf_set;
  logic          grant_b;
  logic          full_w;
  logic          empty_w;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // Tie goes to the requester not served last; a lone requester always wins.
  assign grant_b = (a_req && b_req) ? ~last_q : b_req;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    op_push_d   = op_push_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    count_d     = count_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    stk_load    = 1'b0;
    stk_read    = 1'b0;
    stk_data_in = 16'h0000;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          win_d     = grant_b;
          op_push_d = grant_b ? b_push : a_push;
          wdata_d   = grant_b ? b_wdata : a_wdata;
          state_d   = EXEC;
        end
      end

      EXEC: begin
        err_d = 1'b0;
        if (op_push_q) begin
          if (!full_w) begin
            stk_load    = 1'b1;
            stk_data_in = wdata_q;
            count_d     = count_q + ONE_C;
          end else begin
            err_d   = 1'b1;
            ovf_set = 1'b1;
          end
        end else begin
          if (!empty_w) begin
            stk_read = 1'b1;
            count_d  = count_q - ONE_C;
            if (win_q) b_rdata_d = stk_data_out;
            else       a_rdata_d = stk_data_out;
          end else begin
            err_d   = 1'b1;
            unf_set = 1'b1;
            if (win_q) b_rdata_d = 16'h0000;
            else       a_rdata_d = 16'h0000;
          end
        end
        state_d = DONE;
      end

      DONE: begin
        last_d  = win_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A new error event outranks a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    unf_d = unf_set | (unf_q & ~clr_err);
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      op_push_q <= 1'b0;
      wdata_q   <= 16'h0000;
      err_q     <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      a_rdata_q <= 16'h0000;
      b_rdata_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      op_push_q <= op_push_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_ack   = (state_q == DONE) && !win_q;
  assign b_ack   = (state_q == DONE) &&  win_q;
  assign a_err   = a_ack && err_q;
  assign b_err   = b_ack && err_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign count   = count_q;
  assign full    = full_w;
  assign empty   = empty_w;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_arbiter
// Brief    : Randomized scoreboard bench for stack_arbiter with an attached
//            behavioural stack register and a high-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_stack_arbiter;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          sysclk = 1'b0;
  logic          sysreset = 1'b1;
  logic          a_req = 1'b0, a_push = 1'b0, b_req = 1'b0, b_push = 1'b0;
  logic [15:0]   a_wdata = '0, b_wdata = '0;
  logic [15:0]   a_rdata, b_rdata;
  logic          a_ack, a_err, b_ack, b_err;
  logic [15:0]   stk_data_out, stk_data_in;
  logic          stk_load, stk_read;
  logic [CW-1:0] count;
  logic          full, empty, ovf, unf;
  logic          clr_err = 1'b0;

  stack_arbiter #(.DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .sysreset(sysreset),
    .a_req(a_req), .a_push(a_push), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_push(b_push), .b_wdata(b_wdata), .b_rdata(b_rdata),
    .b_ack(b_ack), .b_err(b_err),
    .stk_data_out(stk_data_out), .stk_data_in(stk_data_in),
    .stk_load(stk_load), .stk_read(stk_read),
    .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf),
    .clr_err(clr_err)
  );

  always #5 sysclk = ~sysclk;

  // External stack register, sharing sysreset with the arbiter.
  logic [15:0] stk_mem [0:63];
  int          stk_sz = 0;

  always @(posedge sysclk) begin
    if (sysreset) stk_sz <= 0;
    else if (stk_load && stk_sz < 64) begin
      stk_mem[6'(stk_sz)] <= stk_data_in;
      stk_sz <= stk_sz + 1;
    end else if (stk_read && stk_sz > 0) stk_sz <= stk_sz - 1;
  end

  assign stk_data_out = (stk_sz > 0) ? stk_mem[6'(stk_sz - 1)] : 16'h0000;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue as the stack plus flag/rdata bookkeeping.
  typedef struct {
    bit          who;
    bit          err;
    logic [15:0] rd;
    int          cnt;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_stk[$];
  bit          m_last;
  bit          m_ovf, m_unf;
  logic [15:0] m_rd [2];

  function automatic void m_reset();
    m_stk.delete();
    exp_q.delete();
    m_last = 1'b1;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_rd[0] = 16'h0;
    m_rd[1] = 16'h0;
  endfunction

  // strobe = {stk_load, stk_read, stk_data_in} expected during the EXEC cycle
  function automatic void m_serve(input bit who, input bit push, input logic [15:0] wd,
                                  input bit clr, output logic [17:0] strobe);
    exp_t e;
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    e.err  = 1'b0;
    strobe = 18'h0;
    if (push) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(wd);
        strobe = {2'b10, wd};
      end else begin
        e.err = 1'b1; m_ovf = 1'b1;
      end
    end else begin
      if (m_stk.size() > 0) begin
        m_rd[who] = m_stk.pop_back();
        strobe = {2'b01, 16'h0};
      end else begin
        e.err = 1'b1; m_unf = 1'b1; m_rd[who] = 16'h0;
      end
    end
    e.who = who; e.rd = m_rd[who]; e.cnt = m_stk.size();
    e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    m_last = who;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT acknowledges.
  always @(negedge sysclk) begin
    exp_t e;
    if (!sysreset) begin
      if (stk_load && stk_read) check("strobe_excl", 64'(1), 64'(0));
      if (!stk_load) check("din_idle", 64'(stk_data_in), 64'(0));
      if (a_ack || b_ack) begin
        if (a_ack && b_ack) check("ack_excl", 64'(1), 64'(0));
        if (exp_q.size() == 0) check("unexpected_ack", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("ack_who", 64'(b_ack), 64'(e.who));
          check("ack_err", 64'(b_ack ? b_err : a_err), 64'(e.err));
          check("rdata", 64'(b_ack ? b_rdata : a_rdata), 64'(e.rd));
          check("count", 64'(count), 64'(e.cnt));
          check("flags", 64'({ovf, unf, full, empty}),
                64'({e.ovf, e.unf, e.cnt == DEPTH, e.cnt == 0}));
          check("stk_depth", 64'(stk_sz), 64'(e.cnt));
        end
      end
    end
  end

  task automatic do_reset();
    sysreset = 1'b1; a_req = 1'b0; b_req = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge sysclk);
    #1 sysreset = 1'b0;
    m_reset();
    check("reset_state",
          64'({count, full, empty, ovf, unf, a_ack, b_ack, a_err, b_err,
               stk_load, stk_read, stk_data_in, a_rdata, b_rdata}),
          64'({CW'(0), 1'b0, 1'b1, 8'b0, 48'b0}));
  endtask

  task automatic do_round(input bit ra, input bit rb, input bit pa, input bit pb,
                          input logic [15:0] wa, input logic [15:0] wb, input bit clr);
    int need, got, edges;
    bit w1;
    logic [17:0] s1, s2;
    need = int'(ra) + int'(rb);
    s2 = 18'h0;
    w1 = (ra && rb) ? ~m_last : rb;
    if (!w1) m_serve(1'b0, pa, wa, clr, s1); else m_serve(1'b1, pb, wb, clr, s1);
    if (need == 2) begin
      if (w1) m_serve(1'b0, pa, wa, clr, s2); else m_serve(1'b1, pb, wb, clr, s2);
    end
    @(posedge sysclk); #1;
    a_req = ra; a_push = pa; a_wdata = wa;
    b_req = rb; b_push = pb; b_wdata = wb;
    clr_err = clr;
    got = 0; edges = 0;
    while (got < need && edges < 16) begin
      @(posedge sysclk); #1;
      edges++;
      if (edges == 1) check("strobe_op1", 64'({stk_load, stk_read, stk_data_in}), 64'(s1));
      if (edges == 4 && need == 2)
        check("strobe_op2", 64'({stk_load, stk_read, stk_data_in}), 64'(s2));
      if (a_ack || b_ack) begin
        got++;
        if (got == 1) check("lat_op1", 64'(edges), 64'(2));
        else          check("lat_op2", 64'(edges), 64'(5));
        if (a_ack) a_req = 1'b0;
        if (b_ack) b_req = 1'b0;
      end
    end
    if (got < need) begin
      check("ack_timeout", 64'(got), 64'(need));
      a_req = 1'b0; b_req = 1'b0;
    end
    clr_err = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge sysclk); #1 clr_err = 1'b1;
    @(posedge sysclk); #1 clr_err = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
    check("clr_flags", 64'({ovf, unf}), 64'(0));
  endtask

  initial begin
    int p;
    bit ra, rb;

    // Single push, then read it back.
    do_reset();
    do_round(1, 0, 1, 0, 16'h1234, 16'h0, 0);
    do_round(1, 0, 0, 0, 16'h0, 16'h0, 0);

    // Simultaneous pushes: A first, B on top.
    do_reset();
    do_round(1, 1, 1, 1, 16'hAAAA, 16'hBBBB, 0);
    do_round(0, 1, 0, 0, 16'h0, 16'h0, 0);

    // Fill, overflow, clear; then overflow while clear is held.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_round(1, 0, 1, 0, 16'(16'h100 + i), 16'h0, 0);
    do_round(1, 0, 1, 0, 16'hDEAD, 16'h0, 0);
    pulse_clr();
    do_round(0, 1, 0, 1, 16'h0, 16'hBEEF, 1);
    pulse_clr();

    // Underflow on empty stack.
    do_reset();
    do_round(0, 1, 0, 0, 16'h0, 16'h0, 0);
    pulse_clr();

    // LIFO ordering across both requesters.
    do_reset();
    for (int i = 1; i <= 3; i++) do_round(1, 0, 1, 0, 16'(i), 16'h0, 0);
    do_round(1, 1, 0, 0, 16'h0, 16'h0, 0);
    do_round(1, 0, 0, 0, 16'h0, 16'h0, 0);

    // Reset while a push is executing.
    do_reset();
    @(posedge sysclk); #1;
    a_req = 1'b1; a_push = 1'b1; a_wdata = 16'h5555;
    @(posedge sysclk); #1;
    check("rst_exec_load", 64'(stk_load), 64'(1));
    sysreset = 1'b1; a_req = 1'b0;
    @(posedge sysclk); #1;
    sysreset = 1'b0;
    m_reset();
    check("rst_abort", 64'({count, ovf, unf, a_ack, b_ack}), 64'(0));
    check("rst_stack", 64'(stk_sz), 64'(0));
    repeat (4) @(posedge sysclk);

    // Randomized traffic: push-heavy, pop-heavy, then balanced.
    for (int r = 0; r < 300; r++) begin
      p  = (r < 100) ? 80 : (r < 200) ? 20 : 50;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1'b1;
      do_round(ra, rb, $urandom_range(0, 99) < p, $urandom_range(0, 99) < p,
               16'($urandom), 16'($urandom), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) pulse_clr();
    end

    repeat (4) @(posedge sysclk);
    #1 check("exp_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter: DEPTH, default 8, number of 16-bit entries in the controlled stack register (minimum 2).
REQ-002 Parameter: CW, default $clog2(DEPTH+1), width of the occupancy count.
REQ-003 Port: sysclk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: sysreset  input  1  synchronous, active-high reset.
REQ-005 Port: a_req / b_req  input  1  requester A / B operation request; held high until that requester's ack.
REQ-006 Port: a_push / b_push  input  1  1 = push, 0 = pop; stable while req is high.
REQ-007 Port: a_wdata / b_wdata  input  16  push data; stable while req is high.
REQ-008 Port: a_rdata / b_rdata  output  16  registered pop result; valid while the matching ack is high.
REQ-009 Port: a_ack / b_ack  output  1  one-cycle completion pulse.
REQ-010 Port: a_err / b_err  output  1  qualifies ack: 1 = operation rejected.
REQ-011 Port: stk_data_out  input  16  top-of-stack from the stack register.
REQ-012 Port: stk_data_in  output  16  push data to the stack register.
REQ-013 Port: stk_load / stk_read  output  1  push / pop strobes to the stack register; never both high.
REQ-014 Port: count  output  CW  current occupancy, 0..DEPTH.
REQ-015 Port: full / empty  output  1  count==DEPTH / count==0, combinational from count.
REQ-016 Port: ovf / unf  output  1  sticky overflow / underflow flags.
REQ-017 Port: clr_err  input  1  clears ovf and unf.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC, DONE; each operation SHALL take exactly 3 cycles.
REQ-019 IDLE: if a_req or b_req is high, the arbiter SHALL latch the winner, its op and its wdata, then move to EXEC; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: when both requests are high, the requester not served last wins; a lone requester always wins.
REQ-021 EXEC, accepted push (count<DEPTH): stk_load=1 and stk_data_in=latched wdata for this one cycle; count SHALL increment at the end of the cycle.
REQ-022 EXEC, accepted pop (count>0): stk_read=1 for this one cycle; stk_data_out SHALL be captured into the winner's rdata register; count SHALL decrement.
REQ-023 EXEC, push when count==DEPTH: no strobe; error recorded; ovf set; count unchanged.
REQ-024 EXEC, pop when count==0: no strobe; error recorded; unf set; rdata=16'h0000.
REQ-025 DONE: the winner's ack SHALL be high for exactly this cycle, with err as recorded; the last-served pointer SHALL update; next state is IDLE.
REQ-026 The loser's ack SHALL stay low; the loser's pending req SHALL be served in the next arbitration.
REQ-027 stk_data_in SHALL hold 0 outside EXEC-push cycles.
REQ-028 rdata registers SHALL hold their value until the next pop served for that requester; push acks SHALL leave rdata unchanged.
REQ-029 ovf/unf SHALL be cleared by clr_err; a set event in the same cycle as clr_err SHALL take priority.
REQ-030 A requester that drops req before its ack SHALL be treated as a protocol violation; behaviour is undefined and not required to be checked.

Reset
REQ-031 When sysreset is high at a clock edge: state=IDLE, count=0, ovf=unf=0, all acks/errs=0, rdata=0, stk_load=stk_read=0, stk_data_in=0, last-served pointer=B (A wins the first tie).
REQ-032 Reset in EXEC or DONE SHALL abandon the operation without an ack; the stack register SHALL share sysreset so that count=0 stays consistent.

Verification
REQ-033 Reset, then A pushes 16'h1234: stk_load is high in cycle 2 with stk_data_in=16'h1234; a_ack=1 and a_err=0 in cycle 3; count=1.
REQ-034 Both request together (A push 16'hAAAA, B push 16'hBBBB) from reset: A is served first, then B; top=16'hBBBB; count=2.
REQ-035 DEPTH=8: 8 pushes succeed, the 9th gives err=1, ovf=1, no stk_load, count=8; then clr_err clears ovf.
REQ-036 Empty stack, B pops: b_err=1, b_rdata=0, unf=1, stk_read never high.
REQ-037 Push 1,2,3 then pop three times: rdata reads 3,2,1 and count returns to 0, with empty=1.
REQ-038 Assert sysreset during EXEC of a push: no ack is issued; count=0 and ovf/unf=0 next cycle.
